// File: rtl/alu_request_responder.sv
// rtl/alu_request_responder.sv - handshaked ALU responder with iterative shift-add multiply
module alu_request_responder #(
    parameter int WIDTH     = 4,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clock_in,
    input  logic                 reset_n_in,
    input  logic                 req_valid_in,
    output logic                 req_ready_out,
    input  logic [3:0]           opcode_in,
    input  logic [WIDTH-1:0]     alu_input1,
    input  logic [WIDTH-1:0]     alu_input2,
    output logic                 resp_valid_out,
    input  logic                 resp_ready_in,
    output logic [WIDTH-1:0]     alu_output,
    output logic                 error_out,
    output logic [CNT_WIDTH-1:0] op_count_out
);
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_EQ  = 4'd3;
    localparam logic [3:0] OP_GT  = 4'd4;

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t               state, state_next;
    logic [WIDTH-1:0]     acc, mcand, mplier, acc_next;
    logic [BW-1:0]        bit_cnt;
    logic [WIDTH-1:0]     result_q, calc_result;
    logic                 err_q, calc_err;
    logic [CNT_WIDTH-1:0] count_q;
    logic                 mul_last;

    assign mul_last = (bit_cnt == BW'(WIDTH - 1));
    // mcand is pre-shifted each cycle, so adding it equals adding (A << i)
    assign acc_next = acc + (mplier[0] ? mcand : '0);

    always_comb begin
        calc_result = '0;
        calc_err    = 1'b0;
        case (opcode_in)
            OP_ADD:  calc_result = alu_input1 + alu_input2;
            OP_SUB:  calc_result = alu_input1 - alu_input2;
            OP_EQ:   calc_result[0] = (alu_input1 == alu_input2);
            OP_GT:   calc_result[0] = ($signed(alu_input1) > $signed(alu_input2));
            OP_MUL:  calc_result = '0;
            default: calc_err = 1'b1;
        endcase
    end

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) state <= IDLE;
        else             state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid_in) state_next = (opcode_in == OP_MUL) ? MUL : DONE;
            MUL:     if (mul_last) state_next = DONE;
            DONE:    if (resp_ready_in) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            bit_cnt  <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            count_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_in) begin
                        if (opcode_in == OP_MUL) begin
                            acc     <= '0;
                            mcand   <= alu_input1;
                            mplier  <= alu_input2;
                            bit_cnt <= '0;
                            err_q   <= 1'b0;
                        end else begin
                            result_q <= calc_result;
                            err_q    <= calc_err;
                        end
                    end
                end
                MUL: begin
                    acc     <= acc_next;
                    mcand   <= mcand << 1;
                    mplier  <= mplier >> 1;
                    bit_cnt <= bit_cnt + 1'b1;
                    if (mul_last) result_q <= acc_next;
                end
                DONE: begin
                    if (resp_ready_in) count_q <= count_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign req_ready_out  = (state == IDLE);
    assign resp_valid_out = (state == DONE);
    assign error_out      = (state == DONE) && err_q;
    assign alu_output     = result_q;
    assign op_count_out   = count_q;
endmodule

// File: tb/tb_alu_request_responder.sv
// tb/tb_alu_request_responder.sv - self-checking bench for alu_request_responder
module tb_alu_request_responder;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [3:0] opcode = '0;
    logic [3:0] in1 = '0;
    logic [3:0] in2 = '0;
    logic       resp_valid;
    logic       resp_ready = 1'b0;
    logic [3:0] alu_out;
    logic       err_out;
    logic [7:0] count;

    int checks = 0;
    int failures = 0;
    int exp_count = 0;

    alu_request_responder #(.WIDTH(4), .CNT_WIDTH(8)) dut (
        .clock_in      (clk),
        .reset_n_in    (rst_n),
        .req_valid_in  (req_valid),
        .req_ready_out (req_ready),
        .opcode_in     (opcode),
        .alu_input1    (in1),
        .alu_input2    (in2),
        .resp_valid_out(resp_valid),
        .resp_ready_in (resp_ready),
        .alu_output    (alu_out),
        .error_out     (err_out),
        .op_count_out  (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] res;
        logic       err;
        int         lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Reference: signed integer arithmetic truncated to 4 bits
    function automatic logic [4:0] ref_op(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        int sa, sb, r;
        logic e;
        sa = {{28{a[3]}}, a};
        sb = {{28{b[3]}}, b};
        r = 0;
        e = 1'b0;
        case (op)
            4'd0:    r = sa + sb;
            4'd1:    r = sa - sb;
            4'd2:    r = sa * sb;
            4'd3:    r = (sa == sb) ? 1 : 0;
            4'd4:    r = (sa > sb) ? 1 : 0;
            default: e = 1'b1;
        endcase
        return {e, r[3:0]};
    endfunction

    // Issue one request, wait for the response, complete the handshake.
    // lat counts clock edges between acceptance and resp_valid rising.
    task automatic run_op(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                          output logic [3:0] res, output logic err, output int lat);
        @(negedge clk);
        check("req_ready_idle", req_ready, 1);
        req_valid = 1'b1;
        opcode = op;
        in1 = a;
        in2 = b;
        @(negedge clk);
        req_valid = 1'b0;
        opcode = 4'($urandom_range(0, 15));
        in1 = 4'($urandom_range(0, 15));
        in2 = 4'($urandom_range(0, 15));
        lat = 0;
        while (!resp_valid && lat < 40) begin
            check("err_low_while_busy", err_out, 0);
            @(negedge clk);
            lat++;
        end
        if (!resp_valid) check("response_timeout", 0, 1);
        res = alu_out;
        err = err_out;
        check("req_ready_busy", req_ready, 0);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        exp_count = (exp_count + 1) % 256;
        check("op_count", count, exp_count);
        check("resp_valid_after_hs", resp_valid, 0);
        check("req_ready_after_hs", req_ready, 1);
    endtask

    initial begin
        vec_t vecs[$];
        logic [3:0] res, r2;
        logic       err, e2;
        logic [4:0] exp;
        logic [3:0] ra, rb, rop;
        int         lat;

        vecs.push_back('{4'd0, 4'd7, 4'd1, 4'h8, 1'b0, 0});
        vecs.push_back('{4'd1, 4'h8, 4'd1, 4'h7, 1'b0, 0});
        vecs.push_back('{4'd4, 4'd7, 4'h8, 4'h1, 1'b0, 0});
        vecs.push_back('{4'd3, 4'hF, 4'hF, 4'h1, 1'b0, 0});
        vecs.push_back('{4'd4, 4'hE, 4'hF, 4'h0, 1'b0, 0});
        vecs.push_back('{4'd2, 4'd3, 4'hE, 4'hA, 1'b0, 4});
        vecs.push_back('{4'd2, 4'h8, 4'hF, 4'h8, 1'b0, 4});
        vecs.push_back('{4'hF, 4'd5, 4'd5, 4'h0, 1'b1, 0});
        vecs.push_back('{4'd3, 4'd2, 4'd5, 4'h0, 1'b0, 0});
        vecs.push_back('{4'd7, 4'd1, 4'd1, 4'h0, 1'b1, 0});
        vecs.push_back('{4'd1, 4'd0, 4'd1, 4'hF, 1'b0, 0});

        #12;
        check("rst_req_ready", req_ready, 1);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_alu_output", alu_out, 0);
        check("rst_error", err_out, 0);
        check("rst_count", count, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, err, lat);
            check($sformatf("vec%0d_result", i), res, vecs[i].res);
            check($sformatf("vec%0d_error", i), err, vecs[i].err);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
        end

        // Backpressure: response must hold while consumer stalls
        @(negedge clk);
        req_valid = 1'b1; opcode = 4'd0; in1 = 4'd2; in2 = 4'd2;
        @(negedge clk);
        opcode = 4'd1; in1 = 4'd9; in2 = 4'd3;
        check("bp_resp_valid", resp_valid, 1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("bp_hold_valid", resp_valid, 1);
            check("bp_hold_output", alu_out, 4'd4);
            check("bp_hold_error", err_out, 0);
            check("bp_hold_ready", req_ready, 0);
            check("bp_hold_count", count, exp_count);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        exp_count = (exp_count + 1) % 256;
        check("bp_count_once", count, exp_count);
        check("bp_valid_drop", resp_valid, 0);
        @(negedge clk);
        resp_ready = 1'b0;
        check("bp_single_hs", count, exp_count);
        check("bp_idle_no_resp", resp_valid, 0);

        // Random operations against the reference model
        for (int i = 0; i < 150; i++) begin
            rop = (i % 3 == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 4));
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            exp = ref_op(rop, ra, rb);
            run_op(rop, ra, rb, res, err, lat);
            check($sformatf("rand op=%0d a=%0h b=%0h result", rop, ra, rb), res, exp[3:0]);
            check($sformatf("rand op=%0d a=%0h b=%0h error", rop, ra, rb), err, exp[4]);
            check("rand_latency", lat, (rop == 4'd2) ? 4 : 0);
        end

        // Exhaustive multiply sweep
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                exp = ref_op(4'd2, 4'(a), 4'(b));
                run_op(4'd2, 4'(a), 4'(b), r2, e2, lat);
                check($sformatf("mul %0h*%0h", a, b), r2, exp[3:0]);
            end
        end

        // Reset mid-multiply aborts the operation
        @(negedge clk);
        req_valid = 1'b1; opcode = 4'd2; in1 = 4'd3; in2 = 4'd3;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_req_ready", req_ready, 1);
        check("midrst_resp_valid", resp_valid, 0);
        check("midrst_output", alu_out, 0);
        check("midrst_error", err_out, 0);
        check("midrst_count", count, 0);
        exp_count = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("post_rst_no_resp", resp_valid, 0);
        end
        run_op(4'd0, 4'd2, 4'd3, res, err, lat);
        check("post_rst_add", res, 4'd5);
        check("post_rst_err", err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_request_responder.md
# alu_request_responder

Handshaked, registered ALU service unit. It accepts one operation request (opcode plus two signed operands) from an initiator over a valid/ready channel, computes the result, and returns it over a second valid/ready channel. Multiply runs as an iterative shift-add; every other operation completes in one cycle. It sits between a sequencer or test driver and the datapath, and is the responding end of the opcode/operand/result interface that ALU stimulus drivers exercise.

## Interface
- WIDTH, 4: operand and result width in bits, two's complement.
- CNT_WIDTH, 8: width of the completed-response counter.

- clock_in  input  1  rising-edge clock.
- reset_n_in  input  1  asynchronous, active-low reset.
- req_valid_in  input  1  request present.
- req_ready_out  output  1  unit can accept a request.
- opcode_in  input  4  0 = add, 1 = sub, 2 = mul, 3 = eq, 4 = gt (signed); all other values are illegal.
- alu_input1  input  WIDTH  operand A, signed.
- alu_input2  input  WIDTH  operand B, signed.
- resp_valid_out  output  1  result is valid.
- resp_ready_in  input  1  consumer accepts the result.
- alu_output  output  WIDTH  result, signed.
- error_out  output  1  set with a response whose opcode was illegal.
- op_count_out  output  CNT_WIDTH  number of completed responses, wraps.

## Operation
- FSM states: IDLE, MUL, DONE.
- req_ready_out = 1 only in IDLE. A request is accepted on a rising edge where req_valid_in and req_ready_out are both 1. Opcode and operands are captured on that edge.
- IDLE, on acceptance:
  - mul: load acc = 0, mcand = A, mplier = B, bit counter = 0, go to MUL.
  - any other opcode: register the result and go to DONE.
- Results:
  - add: A+B mod 2^WIDTH.
  - sub: A−B mod 2^WIDTH.
  - eq: 1 if A==B, else 0, zero-extended.
  - gt: 1 if A>B as signed, else 0, zero-extended.
  - illegal opcode: result 0 and error_out = 1.
- MUL: one bit per cycle, WIDTH iterations.
  - When mplier[i] is 1, acc += (mcand << i) mod 2^WIDTH.
  - The result is the low WIDTH bits of the product, which is correct for signed operands.
  - After the final iteration, go to DONE.
- DONE:
  - resp_valid_out = 1; alu_output and error_out hold stable.
  - On an edge with resp_ready_in = 1: op_count_out increments (wrapping from 2^CNT_WIDTH−1 to 0), resp_valid_out drops, go to IDLE.
- While resp_valid_out is 0, error_out is 0. alu_output keeps its last value and must not be relied on.
- Input changes while not in IDLE are ignored.

## Timing
- Reset (asynchronous assert; release takes effect at the next edge):
  - FSM returns to IDLE.
  - req_ready_out = 1, resp_valid_out = 0, alu_output = 0, error_out = 0, op_count_out = 0.
  - acc and counters are cleared.
- Reset in MUL or DONE aborts the operation: no response is produced and the count does not increment.
- Single-cycle ops: accepted on edge N, resp_valid_out = 1 from after edge N.
- mul: accepted on edge N, resp_valid_out = 1 from after edge N+WIDTH, which is 4 cycles for WIDTH = 4.
- Throughput: one request every 2 cycles at best for single-cycle ops; req_ready_out returns to 1 after the response-handshake edge.
- Backpressure: DONE holds indefinitely while resp_ready_in = 0, and req_ready_out stays 0.
- There is no combinational path from resp_ready_in or req_valid_in to any output.

## Test plan
- Add wrap: A=7, B=1, op 0 → alu_output = 4'h8 (−8) one cycle after acceptance; error_out = 0; op_count_out = 1 after the response handshake.
- Sub/compare: A=−8, B=1, op 1 → 4'h7. A=7, B=−8, op 4 → 1. A=−1, B=−1, op 3 → 1. A=−2, B=−1, op 4 → 0.
- Multiply:
  - A=3, B=−2, op 2 → 4'hA (−6), resp_valid_out rising exactly 4 cycles after acceptance.
  - A=−8, B=−1 → 4'h8.
  - Exhaustive sweep of all 256 operand pairs, checked against the low WIDTH bits of A*B.
- Backpressure: hold resp_ready_in = 0 for 3 cycles after a response appears → alu_output, error_out and resp_valid_out stay stable, req_ready_out stays 0, op_count_out does not change. Releasing resp_ready_in completes one handshake only.
- Illegal opcode 4'hF, A=5, B=5 → alu_output = 0, error_out = 1, response delivered and counted normally.
- Reset mid-mul: assert reset_n_in = 0 two cycles into a mul → all outputs immediately at reset values; after release, a new add of 2+3 returns 5 with op_count_out = 1.
